instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Pipeline IF stage feeding the decode stage through the IF/ID register (`if_id_instruc`, `if_id_nextpc`), and consuming the decode stage's PC-redirect signals. It owns the PC and issues word fetches to the instruction memory controller over a valid/ready handshake. It absorbs execute-stage stalls with a one-entry skid buffer and inserts NOP bubbles while memory is slow. Branches use MIPS delay-slot semantics.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0040, target used when `id_if_selpctype` = 2'b11
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- ex_if_stall  in  1  freeze IF/ID and PC
- id_if_selpcsource  in  1  redirect PC to the selected target
- id_if_selpctype  in  2  target select: 00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
- id_if_rega  in  32  jump-register target
- id_if_pcimd2ext  in  32  branch target
- id_if_pcindex  in  32  jump target
- if_id_instruc  out  32  fetched instruction; 0 = NOP bubble
- if_id_nextpc  out  32  address of `if_id_instruc` + 4
- if_mc_en  out  1  fetch request valid
- if_mc_addr  out  18  word address = pc[19:2]
- mc_if_data  in  32  instruction word, valid when ready
- mc_if_ready  in  1  request complete this cycle

## Operation
- Registers: pc[31:0], state {IDLE, FETCH, FULL}, skid[31:0], pend (1 bit), pend_tgt[31:0].
- Reset values: pc=RESET_PC, state=IDLE, if_id_instruc=0, if_id_nextpc=0, pend=0, skid=0, pend_tgt=0.
- `if_mc_en` = (state==FETCH). `if_mc_addr` = pc[19:2]. Both outputs hold stable while en=1 and ready=0.
- tgt = mux(selpctype). A redirect is valid only when selpcsource=1 and stall=0. It is ignored during a stall; decode re-presents the branch afterwards.
- npc = redirect ? tgt : pend ? pend_tgt : pc+4. A live redirect wins over pend. pc+4 wraps modulo 2^32. pc[1:0] is carried but not used for addressing.
- IDLE: always goes to FETCH on the next edge. if_id holds.
- FETCH, ready=1, stall=0: if_id_instruc<=mc_if_data, if_id_nextpc<=pc+4, pc<=npc, pend<=0. State stays FETCH, giving back-to-back requests.
- FETCH, ready=1, stall=1: skid<=mc_if_data, state<=FULL. pc and if_id hold.
- FETCH, ready=0, stall=0: if_id_instruc<=0 (bubble), if_id_nextpc holds. On a redirect: pend<=1, pend_tgt<=tgt.
- FETCH, ready=0, stall=1: everything holds.
- FULL: if_mc_en=0. When stall=0: if_id_instruc<=skid, if_id_nextpc<=pc+4, pc<=npc, pend<=0, state<=FETCH. When stall=1: hold.
- Delay slot: the instruction at branch+4 is always delivered. The redirect takes effect on the following fetch.
- A redirect arriving during a bubble is stored in pend_tgt, so it is never lost.

## Timing
- First request: `if_mc_en`=1 in the 2nd cycle after reset deasserts (IDLE→FETCH), with addr=RESET_PC[19:2].
- With zero-wait memory (ready tied high): one instruction per cycle. IF/ID updates on the same edge that ready is sampled.
- N wait states: N bubbles are inserted into IF/ID.
- Stall release out of FULL: IF/ID is loaded on the release edge. The next request issues in the following cycle, which costs one cycle.
- Redirect to new address: applied on the edge of the delay slot's completion, so the target request starts the next cycle.
- Reset asserted mid-request: all state clears immediately and `if_mc_en` drops asynchronously. The controller must discard the abandoned request.
- `mc_if_ready` is ignored when `if_mc_en`=0.

## Test plan
- Reset, ready tied 1, NOP-free memory (mem[i]=i+0x100) → addr 0,1,2… on consecutive cycles; IF/ID shows 0x100/4, 0x101/8, 0x102/12.
- Ready asserted every 3rd cycle → two zero bubbles between instructions; `if_mc_addr` stable for 3 cycles per request.
- Branch at pc 0x10 with pcimd2ext=0x80, selpctype=00, ready=1 → delivered sequence is 0x10, 0x14 (delay slot), 0x80; nextpc=0x84 for the target instruction.
- Stall asserted on the ready cycle of pc 0x20 and held 4 cycles → FULL, `if_mc_en`=0, IF/ID frozen; on release IF/ID=mem[0x20], and the next request is addr 0x24>>2 one cycle later.
- Redirect (selpctype=11) during a bubble while pc 0x30 is outstanding; ready comes 2 cycles later → mem[0x30] delivered, next address is EXC_VECTOR (word 0x10).
- pc=0xFFFF_FFFC fetched → if_id_nextpc=0 and the next address is word 0; also assert reset mid-FETCH → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage owning the PC, fetching over valid/ready with a skid buffer and delay-slot redirects
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_if_stall,
  input  logic        id_if_selpcsource,
  input  logic [1:0]  id_if_selpctype,
  input  logic [31:0] id_if_rega,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_pcindex,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_nextpc,
  output logic        if_mc_en,
  output logic [17:0] if_mc_addr,
  input  logic [31:0] mc_if_data,
  input  logic        mc_if_ready
);
  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, skid_q, skid_d, pend_tgt_q, pend_tgt_d;
  logic [31:0] instruc_q, instruc_d, nextpc_q, nextpc_d;
  logic        pend_q, pend_d;
  logic        redirect;
  logic [31:0] tgt, pc4, npc;
  assign tgt = id_if_selpctype == 2'b00 ? id_if_pcimd2ext :
               id_if_selpctype == 2'b01 ? id_if_rega :
               id_if_selpctype == 2'b10 ? id_if_pcindex : EXC_VECTOR;
  assign redirect = id_if_selpcsource && !ex_if_stall;
  assign pc4 = pc_q + 32'd4;
  assign npc = redirect ? tgt : pend_q ? pend_tgt_q : pc4;
  assign if_mc_en = state_q == FETCH;
  assign if_mc_addr = pc_q[19:2];
  assign if_id_instruc = instruc_q;
  assign if_id_nextpc = nextpc_q;
  // Next-state: fetch completion, skid capture on stall, bubble insertion and pending redirect
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    instruc_d  = instruc_q;
    nextpc_d   = nextpc_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mc_if_ready && !ex_if_stall) begin
          instruc_d = mc_if_data;
          nextpc_d  = pc4;
          pc_d      = npc;
          pend_d    = 1'b0;
        end else if (mc_if_ready) begin
          skid_d  = mc_if_data;
          state_d = FULL;
        end else if (!ex_if_stall) begin
          instruc_d = 32'd0;
          if (redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt;
          end
        end
      end
      FULL: begin
        if (!ex_if_stall) begin
          instruc_d = skid_q;
          nextpc_d  = pc4;
          pc_d      = npc;
          pend_d    = 1'b0;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      skid_q     <= 32'd0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
      instruc_q  <= 32'd0;
      nextpc_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      instruc_q  <= instruc_d;
      nextpc_q   <= nextpc_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a transaction-level model
module tb_instruction_fetch;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, src = 1'b0, ready = 1'b0;
  logic [1:0]  ty = 2'b00;
  logic [31:0] rega = 0, imd = 0, pidx = 0;
  logic [31:0] instruc, nextpc, mdata;
  logic        en;
  logic [17:0] addr;
  int          passed = 0, total = 0;
  logic        m_idle, m_held;
  logic [31:0] m_pc, m_word, m_instr, m_npc;
  logic [31:0] pq[$];

  instruction_fetch dut (
    .clock(clock), .reset(reset), .ex_if_stall(stall),
    .id_if_selpcsource(src), .id_if_selpctype(ty),
    .id_if_rega(rega), .id_if_pcimd2ext(imd), .id_if_pcindex(pidx),
    .if_id_instruc(instruc), .if_id_nextpc(nextpc),
    .if_mc_en(en), .if_mc_addr(addr),
    .mc_if_data(mdata), .mc_if_ready(ready)
  );

  always #5 clock = ~clock;
  assign mdata = {14'd0, addr} + 32'h100;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {14'd0, a[19:2]} + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_held = 1'b0; m_pc = 32'h0; m_word = 0; m_instr = 0; m_npc = 0;
    pq.delete();
  endtask

  task automatic cyc(input logic st, input logic rdy, input logic s, input logic [1:0] t_sel, input logic [31:0] t);
    logic [31:0] tg, nx;
    logic        rd;
    stall = st; ready = rdy; src = s; ty = t_sel;
    imd  = t_sel == 2'b00 ? t : $urandom;
    rega = t_sel == 2'b01 ? t : $urandom;
    pidx = t_sel == 2'b10 ? t : $urandom;
    rd = s && !st;
    tg = t_sel == 2'b11 ? 32'h40 : t;
    nx = rd ? tg : (pq.size() != 0 ? pq[0] : m_pc + 32'd4);
    if (m_idle) m_idle = 1'b0;
    else if (m_held) begin
      if (!st) begin
        m_instr = m_word; m_npc = m_pc + 32'd4; m_pc = nx; pq.delete(); m_held = 1'b0;
      end
    end else if (rdy && !st) begin
      m_instr = memw(m_pc); m_npc = m_pc + 32'd4; m_pc = nx; pq.delete();
    end else if (rdy) begin
      m_word = memw(m_pc); m_held = 1'b1;
    end else if (!st) begin
      m_instr = 32'd0;
      if (rd) begin pq.delete(); pq.push_back(tg); end
    end
    @(posedge clock); #1;
    chk("en", {31'd0, en}, {31'd0, !m_idle && !m_held});
    chk("addr", {14'd0, addr}, {14'd0, m_pc[19:2]});
    chk("instruc", instruc, m_instr);
    chk("nextpc", nextpc, m_npc);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_addr", {14'd0, addr}, 32'd0);
    chk("rst_instr", instruc, 32'd0);
    chk("rst_npc", nextpc, 32'd0);
    reset = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("first_req", {31'd0, en}, 32'd1);
    cyc(0, 1, 0, 0, 0);
    chk("zw0", instruc, 32'h100);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("zw2", instruc, 32'h102);
    chk("zw2_npc", nextpc, 32'hC);
    cyc(0, 0, 0, 0, 0);
    chk("bub1", instruc, 32'h0);
    chk("hold_addr1", {14'd0, addr}, 32'h3);
    cyc(0, 0, 0, 0, 0);
    chk("hold_addr2", {14'd0, addr}, 32'h3);
    cyc(0, 1, 0, 0, 0);
    chk("slow_deliv", instruc, 32'h103);
    cyc(0, 1, 0, 0, 0);
    chk("br_instr", instruc, 32'h104);
    cyc(0, 1, 1, 2'b00, 32'h80);
    chk("delay_slot", instruc, 32'h105);
    chk("br_tgt_addr", {14'd0, addr}, 32'h20);
    cyc(0, 1, 0, 0, 0);
    chk("tgt_instr", instruc, 32'h120);
    chk("tgt_npc", nextpc, 32'h84);
    cyc(0, 1, 1, 2'b10, 32'h20);
    cyc(1, 1, 0, 0, 0);
    chk("full_en", {31'd0, en}, 32'd0);
    chk("full_frozen", instruc, 32'h121);
    repeat (3) cyc(1, 1'($urandom_range(0, 1)), 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("rel_instr", instruc, 32'h108);
    chk("rel_addr", {14'd0, addr}, 32'h9);
    chk("rel_en", {31'd0, en}, 32'd1);
    cyc(0, 1, 1, 2'b01, 32'h30);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2'b11, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("pend_instr", instruc, 32'h10C);
    chk("exc_addr", {14'd0, addr}, 32'h10);
    cyc(0, 1, 1, 2'b10, 32'hFFFF_FFFC);
    chk("wrap_addr", {14'd0, addr}, 32'h3FFFF);
    cyc(0, 1, 0, 0, 0);
    chk("wrap_npc", nextpc, 32'h0);
    chk("wrap_next", {14'd0, addr}, 32'h0);
    cyc(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_en", {31'd0, en}, 32'd0);
    chk("arst_instr", instruc, 32'd0);
    chk("arst_npc", nextpc, 32'd0);
    chk("arst_addr", {14'd0, addr}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
          2'($urandom_range(0, 3)), $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
